// File: rtl/dwt_fir_sched.sv
// dwt_fir_sched: round-robin scheduler sharing one pipelined 4-tap FIR MAC
// engine between the four DWT filter channels (0 Lo_D, 1 Hi_D, 2 Lo_R, 3 Hi_R).
// Each channel keeps a 3-sample history and a 4-tap coefficient bank. The block
// issues one tap vector per cycle and realigns the channel tag with the result.
//
// Optional feature macro: DWT_SCHED_CFG_EN adds a coefficient write port
// (cfg_we, cfg_ch, cfg_tap, cfg_data). Without it the banks are constants.
//
// Ports:
//   clk, rstn                clock, asynchronous active-low reset
//   sched_en                 grant enable (in-flight results still drain)
//   ch_valid[3:0], ch_x      per-channel sample valid / packed samples
//   ch_ready[3:0]            per-channel grant (combinational, one-hot)
//   hist_clr[3:0]            per-channel synchronous history clear
//   mac_vld, mac_x0..3       registered issue strobe and tap vector
//   mac_c0..3                registered coefficient bank of the issued channel
//   mac_y                    engine result, MAC_LAT cycles after mac_vld
//   y, y_ch, y_valid         result, its channel tag and strobe
module dwt_fir_sched #(
  parameter int unsigned W_IN    = 9,
  parameter int unsigned C_IN    = 9,
  parameter int unsigned Y_OUT   = 25,
  parameter int unsigned MAC_LAT = 5
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                sched_en,
  input  logic [3:0]          ch_valid,
  input  logic [4*W_IN-1:0]   ch_x,
  output logic [3:0]          ch_ready,
  input  logic [3:0]          hist_clr,
`ifdef DWT_SCHED_CFG_EN
  input  logic                cfg_we,
  input  logic [1:0]          cfg_ch,
  input  logic [1:0]          cfg_tap,
  input  logic [C_IN-1:0]     cfg_data,
`endif
  output logic                mac_vld,
  output logic [W_IN-1:0]     mac_x0,
  output logic [W_IN-1:0]     mac_x1,
  output logic [W_IN-1:0]     mac_x2,
  output logic [W_IN-1:0]     mac_x3,
  output logic [C_IN-1:0]     mac_c0,
  output logic [C_IN-1:0]     mac_c1,
  output logic [C_IN-1:0]     mac_c2,
  output logic [C_IN-1:0]     mac_c3,
  input  logic [Y_OUT-1:0]    mac_y,
  output logic [Y_OUT-1:0]    y,
  output logic [1:0]          y_ch,
  output logic                y_valid
);

  localparam int unsigned N_CH  = 4;
  localparam int unsigned N_TAP = 4;
  localparam int unsigned N_HIS = 3;

  // Reset coefficient banks {c0, c1, c2, c3} per channel
  localparam int COEF_RST [N_CH][N_TAP] = '{
    '{ -34,   57,  214,  123},
    '{-123,  214,  -57,  -34},
    '{ 123,  214,   57,  -34},
    '{ -34,  -57,  214, -123}
  };

  logic [W_IN-1:0] x_arr [N_CH];
  logic [W_IN-1:0] hist  [N_CH][N_HIS];
  logic [C_IN-1:0] coef  [N_CH][N_TAP];
  logic [1:0]      rr;
  logic            grant_vld_c;
  logic [1:0]      grant_ch_c;
  logic [1:0]      mac_ch;
  logic [MAC_LAT-1:0] tag_vld;
  logic [1:0]      tag_ch [MAC_LAT];

  // Unpack per-channel samples
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      x_arr[i] = ch_x[i*W_IN +: W_IN];
    end
  end

  // Round-robin search from rr; scanning downwards lets the nearest valid win
  always_comb begin
    grant_vld_c = 1'b0;
    grant_ch_c  = 2'd0;
    if (rstn && sched_en) begin
      for (int k = 3; k >= 0; k--) begin
        if (ch_valid[rr + 2'(k)]) begin
          grant_vld_c = 1'b1;
          grant_ch_c  = rr + 2'(k);
        end
      end
    end
  end

  assign ch_ready = grant_vld_c ? (4'b0001 << grant_ch_c) : 4'b0000;

  // Round-robin pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr <= 2'd0;
    end else if (grant_vld_c) begin
      rr <= grant_ch_c + 2'd1;
    end
  end

`ifdef DWT_SCHED_CFG_EN
  // Writable banks; a same-cycle issue still reads the old value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_CH; i++) begin
        for (int t = 0; t < N_TAP; t++) begin
          coef[i][t] <= C_IN'(COEF_RST[i][t]);
        end
      end
    end else if (cfg_we) begin
      coef[cfg_ch][cfg_tap] <= cfg_data;
    end
  end
`else
  // Constant banks
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      for (int t = 0; t < N_TAP; t++) begin
        coef[i][t] = C_IN'(COEF_RST[i][t]);
      end
    end
  end
`endif

  // Sample histories; a clear coinciding with a transfer keeps the new sample
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_CH; i++) begin
        for (int j = 0; j < N_HIS; j++) begin
          hist[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (grant_vld_c && (grant_ch_c == 2'(i))) begin
          hist[i][0] <= x_arr[i];
          hist[i][1] <= hist_clr[i] ? '0 : hist[i][0];
          hist[i][2] <= hist_clr[i] ? '0 : hist[i][1];
        end else if (hist_clr[i]) begin
          for (int j = 0; j < N_HIS; j++) begin
            hist[i][j] <= '0;
          end
        end
      end
    end
  end

  // Issue registers; tap vector and bank hold when idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mac_vld <= 1'b0;
      mac_ch  <= 2'd0;
      mac_x0  <= '0;
      mac_x1  <= '0;
      mac_x2  <= '0;
      mac_x3  <= '0;
      mac_c0  <= C_IN'(COEF_RST[0][0]);
      mac_c1  <= C_IN'(COEF_RST[0][1]);
      mac_c2  <= C_IN'(COEF_RST[0][2]);
      mac_c3  <= C_IN'(COEF_RST[0][3]);
    end else begin
      mac_vld <= grant_vld_c;
      if (grant_vld_c) begin
        mac_ch <= grant_ch_c;
        mac_x0 <= x_arr[grant_ch_c];
        mac_x1 <= hist[grant_ch_c][0];
        mac_x2 <= hist[grant_ch_c][1];
        mac_x3 <= hist[grant_ch_c][2];
        mac_c0 <= coef[grant_ch_c][0];
        mac_c1 <= coef[grant_ch_c][1];
        mac_c2 <= coef[grant_ch_c][2];
        mac_c3 <= coef[grant_ch_c][3];
      end
    end
  end

  // Tag pipe follows mac_vld so its tail lines up with mac_y
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_vld <= '0;
      for (int i = 0; i < MAC_LAT; i++) begin
        tag_ch[i] <= 2'd0;
      end
    end else begin
      tag_vld[0] <= mac_vld;
      tag_ch[0]  <= mac_ch;
      for (int i = 1; i < MAC_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_ch[i]  <= tag_ch[i-1];
      end
    end
  end

  assign y_valid = tag_vld[MAC_LAT-1];
  assign y_ch    = tag_ch[MAC_LAT-1];
  assign y       = mac_y;

endmodule

// File: tb/tb_dwt_fir_sched.sv
// Bench for dwt_fir_sched: a reference grant/history model pushes expected
// issues and results into queues, which are popped when mac_vld / y_valid
// fire. A behavioural MAC engine of depth MAC_LAT drives mac_y.
module tb_dwt_fir_sched;

  localparam int unsigned W   = 9;
  localparam int unsigned C   = 9;
  localparam int unsigned YW  = 25;
  localparam int unsigned LAT = 5;

  localparam int BANK [4][4] = '{
    '{ -34,   57,  214,  123},
    '{-123,  214,  -57,  -34},
    '{ 123,  214,   57,  -34},
    '{ -34,  -57,  214, -123}
  };

  typedef struct packed {
    logic [1:0]   ch;
    logic [W-1:0] x0, x1, x2, x3;
    logic [C-1:0] c0, c1, c2, c3;
  } iss_t;

  typedef struct packed {
    logic [1:0]    ch;
    logic [YW-1:0] y;
    logic [31:0]   due;
  } res_t;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           sched_en = 1'b0;
  logic [3:0]     ch_valid = '0;
  logic [4*W-1:0] ch_x = '0;
  logic [3:0]     ch_ready;
  logic [3:0]     hist_clr = '0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [1:0]     cfg_tap = '0;
  logic [C-1:0]   cfg_data = '0;
  logic           mac_vld;
  logic [W-1:0]   mac_x0, mac_x1, mac_x2, mac_x3;
  logic [C-1:0]   mac_c0, mac_c1, mac_c2, mac_c3;
  logic [YW-1:0]  mac_y;
  logic [YW-1:0]  y;
  logic [1:0]     y_ch;
  logic           y_valid;

  dwt_fir_sched #(.W_IN(W), .C_IN(C), .Y_OUT(YW), .MAC_LAT(LAT)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .sched_en (sched_en),
    .ch_valid (ch_valid),
    .ch_x     (ch_x),
    .ch_ready (ch_ready),
    .hist_clr (hist_clr),
`ifdef DWT_SCHED_CFG_EN
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_tap  (cfg_tap),
    .cfg_data (cfg_data),
`endif
    .mac_vld  (mac_vld),
    .mac_x0   (mac_x0),
    .mac_x1   (mac_x1),
    .mac_x2   (mac_x2),
    .mac_x3   (mac_x3),
    .mac_c0   (mac_c0),
    .mac_c1   (mac_c1),
    .mac_c2   (mac_c2),
    .mac_c3   (mac_c3),
    .mac_y    (mac_y),
    .y        (y),
    .y_ch     (y_ch),
    .y_valid  (y_valid)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  // Behavioural engine: signed 4-tap dot product, LAT cycles after mac_vld
  logic [YW-1:0] eng [LAT];
  always @(posedge clk) begin
    eng[0] <= YW'(int'($signed(mac_x0)) * int'($signed(mac_c0)) +
                  int'($signed(mac_x1)) * int'($signed(mac_c1)) +
                  int'($signed(mac_x2)) * int'($signed(mac_c2)) +
                  int'($signed(mac_x3)) * int'($signed(mac_c3)));
    for (int i = 1; i < LAT; i++) eng[i] <= eng[i-1];
  end
  assign mac_y = eng[LAT-1];

  int checks = 0;
  int errors = 0;

  iss_t iq[$];
  res_t rq[$];
  logic [W-1:0] m_hist [4][3];
  logic [C-1:0] m_coef [4][4];
  logic [1:0]   m_rr;
  logic [3:0]   exp_ready;
  logic [3:0]   rdy;

  function automatic logic [4*W-1:0] pk(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  function automatic logic [YW-1:0] dot(input iss_t e);
    int acc;
    acc = int'($signed(e.x0)) * int'($signed(e.c0)) + int'($signed(e.x1)) * int'($signed(e.c1)) +
          int'($signed(e.x2)) * int'($signed(e.c2)) + int'($signed(e.x3)) * int'($signed(e.c3));
    return YW'(acc);
  endfunction

  task automatic model_reset();
    m_rr = 2'd0;
    exp_ready = 4'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) m_hist[i][j] = '0;
      for (int t = 0; t < 4; t++) m_coef[i][t] = C'(BANK[i][t]);
    end
    iq.delete();
    rq.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    ch_valid = '0;
    ch_x = '0;
    hist_clr = '0;
    sched_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // One clock: drive inputs, predict grant, pop/compare scoreboard at negedge
  task automatic cyc(input logic [3:0] v, input logic [4*W-1:0] x, input logic [3:0] clr,
                     input logic en, output logic [3:0] rdy_obs);
    logic       g_vld;
    logic [1:0] g;
    logic [1:0] idx;
    iss_t e;
    iss_t o;
    res_t r;
    ch_valid = v;
    ch_x = x;
    hist_clr = clr;
    sched_en = en;
    g_vld = 1'b0;
    g = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = m_rr + 2'(k);
      if (en && v[idx]) begin
        g_vld = 1'b1;
        g = idx;
      end
    end
    exp_ready = g_vld ? (4'b0001 << g) : 4'b0000;
    if (g_vld) begin
      e.ch = g;
      e.x0 = x[g*W +: W];
      e.x1 = m_hist[g][0];
      e.x2 = m_hist[g][1];
      e.x3 = m_hist[g][2];
      e.c0 = m_coef[g][0];
      e.c1 = m_coef[g][1];
      e.c2 = m_coef[g][2];
      e.c3 = m_coef[g][3];
      iq.push_back(e);
      r.ch = g;
      r.y = dot(e);
      r.due = 32'(cyc_cnt + 1 + int'(LAT));
      rq.push_back(r);
      m_hist[g][2] = clr[g] ? '0 : m_hist[g][1];
      m_hist[g][1] = clr[g] ? '0 : m_hist[g][0];
      m_hist[g][0] = x[g*W +: W];
      m_rr = g + 2'd1;
    end
    for (int i = 0; i < 4; i++) begin
      if (clr[i] && !(g_vld && (g == 2'(i)))) begin
        for (int j = 0; j < 3; j++) m_hist[i][j] = '0;
      end
    end
    @(negedge clk);
    rdy_obs = ch_ready;
    checks++;
    if (ch_ready !== exp_ready) begin
      errors++;
      $display("FAIL ch_ready: got %b expected %b at cycle %0d", ch_ready, exp_ready, cyc_cnt);
    end
    if (mac_vld === 1'b1) begin
      checks++;
      if (iq.size() == 0) begin
        errors++;
        $display("FAIL issue: unexpected mac_vld at cycle %0d", cyc_cnt);
      end else begin
        e = iq.pop_front();
        o = {e.ch, mac_x0, mac_x1, mac_x2, mac_x3, mac_c0, mac_c1, mac_c2, mac_c3};
        if (o !== e) begin
          errors++;
          $display("FAIL issue ch%0d: got x=%h,%h,%h,%h c=%h,%h,%h,%h expected x=%h,%h,%h,%h c=%h,%h,%h,%h",
                   e.ch, mac_x0, mac_x1, mac_x2, mac_x3, mac_c0, mac_c1, mac_c2, mac_c3,
                   e.x0, e.x1, e.x2, e.x3, e.c0, e.c1, e.c2, e.c3);
        end
      end
    end
    if (y_valid === 1'b1) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL result: unexpected y_valid at cycle %0d", cyc_cnt);
      end else begin
        r = rq.pop_front();
        if (y_ch !== r.ch || y !== r.y) begin
          errors++;
          $display("FAIL result: got ch%0d y=%0d expected ch%0d y=%0d",
                   y_ch, $signed(y), r.ch, $signed(r.y));
        end
        checks++;
        if (32'(cyc_cnt) != r.due) begin
          errors++;
          $display("FAIL latency: y_valid at cycle %0d expected %0d", cyc_cnt, r.due);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (iq.size() != 0 || rq.size() != 0); i++) cyc(4'b0, '0, 4'b0, 1'b1, rdy);
    checks++;
    if (iq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d issues and %0d results still pending, expected 0", iq.size(), rq.size());
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    ch_valid = 4'hF;
    sched_en = 1'b1;
    #2;
    checks++;
    if (ch_ready !== 4'b0 || mac_vld !== 1'b0 || y_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got ready=%b mac_vld=%b y_valid=%b expected 0,0,0", ch_ready, mac_vld, y_valid);
    end
    do_reset();
    checks++;
    if ({mac_x0, mac_x1, mac_x2, mac_x3} !== '0) begin
      errors++;
      $display("FAIL reset_mac_x: got %h expected 0", {mac_x0, mac_x1, mac_x2, mac_x3});
    end
    checks++;
    if (y_valid !== 1'b0 || y_ch !== 2'd0 || mac_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got y_valid=%b y_ch=%0d mac_vld=%b expected 0,0,0", y_valid, y_ch, mac_vld);
    end
  endtask

  task automatic test_single_channel();
    do_reset();
    cyc(4'b0100, pk(0, 0, 1, 0), 4'b0, 1'b1, rdy);
    checks++;
    if (mac_x0 !== W'(1) || mac_c0 !== C'(123) || mac_c3 !== C'(-34)) begin
      errors++;
      $display("FAIL single_first: got x0=%0d c0=%0d c3=%0d expected 1,123,-34",
               mac_x0, $signed(mac_c0), $signed(mac_c3));
    end
    for (int i = 0; i < 3; i++) cyc(4'b0100, pk(0, 0, 0, 0), 4'b0, 1'b1, rdy);
    drain();
  endtask

  task automatic test_round_robin();
    int cnt [4];
    do_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int n = 0; n < 100; n++) begin
      cyc(4'hF, 36'({4'($urandom), 32'($urandom)}), 4'b0, 1'b1, rdy);
      for (int i = 0; i < 4; i++) if (rdy[i]) cnt[i]++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt[i] != 25) begin
        errors++;
        $display("FAIL rr_count ch%0d: got %0d grants expected 25", i, cnt[i]);
      end
    end
    drain();
  endtask

  task automatic test_rr_start();
    do_reset();
    cyc(4'b0010, pk(0, 11, 0, 0), 4'b0, 1'b1, rdy);
    cyc(4'b1010, pk(0, 21, 0, 31), 4'b0, 1'b1, rdy);
    checks++;
    if (rdy !== 4'b1000) begin
      errors++;
      $display("FAIL rr_first: got %b expected 1000", rdy);
    end
    cyc(4'b1010, pk(0, 22, 0, 32), 4'b0, 1'b1, rdy);
    checks++;
    if (rdy !== 4'b0010) begin
      errors++;
      $display("FAIL rr_second: got %b expected 0010", rdy);
    end
    checks++;
    if (mac_x1 !== W'(11)) begin
      errors++;
      $display("FAIL rr_hist: ch1 x1 got %0d expected 11", mac_x1);
    end
    cyc(4'b1010, pk(0, 23, 0, 33), 4'b0, 1'b1, rdy);
    cyc(4'b1010, pk(0, 24, 0, 34), 4'b0, 1'b1, rdy);
    drain();
  endtask

  task automatic test_hist_clr();
    do_reset();
    cyc(4'b0001, pk(9, 0, 0, 0), 4'b0, 1'b1, rdy);
    cyc(4'b0001, pk(8, 0, 0, 0), 4'b0, 1'b1, rdy);
    cyc(4'b0001, pk(7, 0, 0, 0), 4'b0, 1'b1, rdy);
    cyc(4'b0001, pk(5, 0, 0, 0), 4'b0001, 1'b1, rdy);
    checks++;
    if ({mac_x0, mac_x1, mac_x2, mac_x3} !== {W'(5), W'(7), W'(8), W'(9)}) begin
      errors++;
      $display("FAIL clr_issue: got %0d,%0d,%0d,%0d expected 5,7,8,9", mac_x0, mac_x1, mac_x2, mac_x3);
    end
    cyc(4'b0001, pk(6, 0, 0, 0), 4'b0, 1'b1, rdy);
    checks++;
    if ({mac_x0, mac_x1, mac_x2, mac_x3} !== {W'(6), W'(5), W'(0), W'(0)}) begin
      errors++;
      $display("FAIL clr_next: got %0d,%0d,%0d,%0d expected 6,5,0,0", mac_x0, mac_x1, mac_x2, mac_x3);
    end
    drain();
  endtask

  task automatic test_sched_en();
    do_reset();
    for (int n = 0; n < 4; n++) cyc(4'hF, pk(n + 1, n + 2, n + 3, n + 4), 4'b0, 1'b1, rdy);
    for (int n = 0; n < 10; n++) begin
      cyc(4'hF, pk(40, 41, 42, 43), 4'b0, 1'b0, rdy);
      checks++;
      if (rdy !== 4'b0 || mac_vld !== 1'b0) begin
        errors++;
        $display("FAIL sched_off %0d: got ready=%b mac_vld=%b expected 0000,0", n, rdy, mac_vld);
      end
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    int stale;
    do_reset();
    cyc(4'b0111, pk(3, 4, 5, 0), 4'b0, 1'b1, rdy);
    cyc(4'b0111, pk(3, 4, 5, 0), 4'b0, 1'b1, rdy);
    cyc(4'b0111, pk(3, 4, 5, 0), 4'b0, 1'b1, rdy);
    rstn = 1'b0;
    #1;
    checks++;
    if (y_valid !== 1'b0 || mac_vld !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got y_valid=%b mac_vld=%b expected 0,0", y_valid, mac_vld);
    end
    do_reset();
    stale = 0;
    for (int n = 0; n < int'(LAT) + 4; n++) begin
      cyc(4'b0, '0, 4'b0, 1'b1, rdy);
      if (y_valid === 1'b1) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL stale: got %0d stale results expected 0", stale);
    end
  endtask

`ifdef DWT_SCHED_CFG_EN
  task automatic test_cfg();
    do_reset();
    cfg_we = 1'b1;
    cfg_ch = 2'd2;
    cfg_tap = 2'd0;
    cfg_data = C'(100);
    cyc(4'b0, '0, 4'b0, 1'b1, rdy);
    cfg_we = 1'b0;
    m_coef[2][0] = C'(100);
    cyc(4'b0100, pk(0, 0, 3, 0), 4'b0, 1'b1, rdy);
    checks++;
    if (mac_c0 !== C'(100)) begin
      errors++;
      $display("FAIL cfg_write: got c0=%0d expected 100", $signed(mac_c0));
    end
    // Write coinciding with a ch2 issue only affects the following issue
    cfg_we = 1'b1;
    cfg_tap = 2'd1;
    cfg_data = C'(77);
    cyc(4'b0100, pk(0, 0, 2, 0), 4'b0, 1'b1, rdy);
    cfg_we = 1'b0;
    m_coef[2][1] = C'(77);
    cyc(4'b0100, pk(0, 0, 1, 0), 4'b0, 1'b1, rdy);
    checks++;
    if (mac_c1 !== C'(77)) begin
      errors++;
      $display("FAIL cfg_same_cycle: got c1=%0d expected 77", $signed(mac_c1));
    end
    drain();
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_single_channel();
    test_round_robin();
    test_rr_start();
    test_hist_clr();
    test_sched_en();
    test_reset_midflight();
`ifdef DWT_SCHED_CFG_EN
    test_cfg();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/dwt_fir_sched.md
# dwt_fir_sched

Round-robin scheduler that time-shares one pipelined 4-tap FIR MAC engine between the four DWT filter channels (Lo_D, Hi_D, Lo_R, Hi_R). It keeps each channel's 3-sample history and coefficient bank and issues one tap vector per cycle to the engine. It tags each issue with its channel and realigns the tag with the engine result. It sits between the up/down-sampling stages and the shared MAC, and replaces one dedicated FIR instance per channel.

## Interface
- w_in, 9, sample width (signed)
- c_in, 9, coefficient width (signed)
- y_out, 25, MAC result width (signed)
- MAC_LAT, 5, engine latency in cycles from issue to result (≥1)

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- sched_en  in  1  1 = grants allowed; 0 = no new grants, in-flight results still drain
- ch_valid  in  4  per-channel sample valid
- ch_x  in  4*w_in  per-channel sample; channel i occupies bits [i*w_in +: w_in]
- ch_ready  out  4  per-channel grant; a transfer happens when ch_valid[i] & ch_ready[i]
- hist_clr  in  4  per-channel history clear (synchronous)
- mac_vld  out  1  issue strobe to the engine
- mac_x0..mac_x3  out  w_in each  x[n], x[n-1], x[n-2], x[n-3]
- mac_c0..mac_c3  out  c_in each  coefficient bank of the granted channel
- mac_y  in  y_out  engine result, valid MAC_LAT cycles after mac_vld
- y  out  y_out  result (mac_y passed through)
- y_ch  out  2  channel tag of y
- y_valid  out  1  result strobe

## Operation
- Arbitration: combinational round-robin over ch_valid, starting the search at pointer rr.
  - At most one ch_ready bit is high per cycle, and it is high only if the matching ch_valid is high and sched_en = 1.
  - After a grant to channel g, rr ← (g+1) mod 4. With no grant, rr holds.
- Issue on transfer of channel g:
  - mac_vld = 1.
  - mac_x0 = ch_x[g]; mac_x1..3 = hist[g][0..2].
  - mac_c0..3 = coef[g][0..3].
  - Outputs are registered, so they appear the cycle after the transfer.
  - hist[g] ← {ch_x[g], hist[g][0], hist[g][1]}.
  - Non-granted histories hold.
- With no transfer, mac_vld = 0 and the mac_x/mac_c outputs hold their last values.
- hist_clr[i] zeroes hist[i] at the clock edge.
  - If channel i transfers in the same cycle, the issue uses the old history, then the history becomes {ch_x[i], 0, 0}.
- Tag pipe: a MAC_LAT-deep shift register of {valid, ch} is loaded in step with mac_vld.
  - y_valid / y_ch are the pipe outputs; y = mac_y.
- Reset coefficient banks {c0, c1, c2, c3}:
  - ch0 Lo_D {-34, 57, 214, 123}
  - ch1 Hi_D {-123, 214, -57, -34}
  - ch2 Lo_R {123, 214, 57, -34}
  - ch3 Hi_R {-34, -57, 214, -123}
- No arithmetic is done in this block; widths pass through unchanged.

## Timing
- Issue latency: transfer at edge k → mac_vld high during cycle k+1.
- Result: y_valid high MAC_LAT cycles after mac_vld, so MAC_LAT+1 cycles after the transfer.
- Throughput: one sample per cycle in aggregate. With all four channels valid, each is granted every 4th cycle in order rr, rr+1, ….
- Reset values: ch_ready 0, mac_vld 0, mac_x*/history 0, mac_c* = reset banks, rr 0, tag pipe 0, y_valid 0, y_ch 0.
- Reset asserted mid-operation: in-flight tags are discarded (y_valid drops immediately) and histories clear. Coefficients return to the reset banks.
- sched_en falling: the grant stops that cycle, and already-issued results still emerge on y_valid.

## Configuration
- DWT_SCHED_CFG_EN defined:
  - Adds inputs cfg_we (1), cfg_ch (2), cfg_tap (2), cfg_data (c_in).
  - cfg_we writes coef[cfg_ch][cfg_tap] at the edge.
  - A write to a bank issued in the same cycle affects only later issues.
- Not defined: coefficient banks are constants equal to the reset values, and there are no cfg ports.

## Test plan
- Single channel 2 (Lo_R), samples 1, 0, 0, 0 → issues with mac_x = (1,0,0,0), (0,1,0,0), (0,0,1,0), (0,0,0,1), all with mac_c = (123, 214, 57, -34). With a model MAC, y = 123, 214, 57, -34 on y_ch = 2, y_valid MAC_LAT+1 cycles after each transfer.
- All four channels valid continuously from reset → grant order 0, 1, 2, 3, 0…. Each channel gets exactly 25 grants in 100 cycles, and y_ch sequence = 0, 1, 2, 3 repeated.
- Channels 1 and 3 valid, rr = 2 → channel 3 is granted first, then channel 1. Channel 1's history is unaffected by channel 3's samples.
- hist_clr[0] pulsed together with a channel 0 transfer of x = 5 after history (7, 8, 9) → that issue is (5, 7, 8, 9); the next sample 6 issues (6, 5, 0, 0).
- sched_en = 0 for 10 cycles with all channels valid → ch_ready = 0 and mac_vld = 0 throughout. Results issued before the drop still emerge.
- rstn asserted while 3 results are in flight → y_valid = 0 immediately, and no stale result appears after release. With DWT_SCHED_CFG_EN, write ch2 tap0 = 100 and confirm the next ch2 issue carries mac_c0 = 100.
